// File: rtl/mux_arb_pkg.sv
// Shared definitions for the wormhole mux arbiter and the router that feeds it:
// flit type codes, channel/credit sizing and the arbiter FSM encoding.
package mux_arb_pkg;

    localparam int VCH    = 4;
    localparam int VCHW   = $clog2(VCH);
    localparam int CREDIT = 4;

    typedef enum logic [1:0] {
        FLIT_NONE = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_DATA = 2'b10,
        FLIT_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY0 = 2'b01,
        ST_BUSY1 = 2'b10
    } arb_state_e;

    // Mux select pattern for a given input port.
    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/credit_cnt.sv
// Per-VC downstream credit counter (0..CREDIT). Simultaneous inc/dec cancel;
// a credit return on a full counter is dropped and flagged as overflow.
module credit_cnt #(
    parameter int CREDIT = 4,
    parameter int CW     = $clog2(CREDIT + 1)
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam logic [CW-1:0] FULL = CW'(CREDIT);

    logic [CW-1:0] count_r;

    // Overflow only when the return would actually push the count past full.
    always_comb begin
        overflow = inc & ~dec & (count_r == FULL);
    end

    // Credit count update.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count_r <= FULL;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    if (count_r != FULL) count_r <= count_r + CW'(1);
                end
                2'b01: begin
                    if (count_r != '0) count_r <= count_r - CW'(1);
                end
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;

endmodule

// File: rtl/mux_arb.sv
// Two-port wormhole arbiter for a 2:1 flit mux: round-robin on HEAD flits,
// holds the winner until its TAIL, and gates every flit on downstream VC credit.
module mux_arb #(
    parameter int VCH    = mux_arb_pkg::VCH,
    parameter int CREDIT = mux_arb_pkg::CREDIT
) (
    input  logic                    clk,
    input  logic                    rst_,
    input  logic [1:0]              itype_0,
    input  logic                    ivalid_0,
    input  logic [$clog2(VCH)-1:0]  ivch_0,
    input  logic [1:0]              itype_1,
    input  logic                    ivalid_1,
    input  logic [$clog2(VCH)-1:0]  ivch_1,
    input  logic [VCH-1:0]          icredit,
    output logic [1:0]              sel,
    output logic                    ogrant_0,
    output logic                    ogrant_1,
    output logic                    oerr
);

    import mux_arb_pkg::*;

    localparam int VW = $clog2(VCH);
    localparam int CW = $clog2(CREDIT + 1);

    arb_state_e      state_r;
    logic [1:0]      sel_r;
    logic            rr_r;
    logic [VW-1:0]   lock_vc_r;
    logic            first_r;
    logic            oerr_r;

    logic [CW-1:0]   credit_s [VCH];
    logic [VCH-1:0]  dec_s;
    logic [VCH-1:0]  ovf_s;

    logic            cand0_s;
    logic            cand1_s;
    logic            win_any_s;
    logic            win_port_s;
    logic            act_port_s;
    logic            act_valid_s;
    logic [1:0]      act_type_s;
    logic            lock_ok_s;
    logic            gnt0_s;
    logic            gnt1_s;
    logic            gnt_s;
    logic            proto_err_s;

    // One credit counter per downstream VC; only the locked VC is ever decremented.
    for (genvar v = 0; v < VCH; v++) begin : g_cc
        assign dec_s[v] = gnt_s & (lock_vc_r == VW'(v));

        credit_cnt #(
            .CREDIT (CREDIT),
            .CW     (CW)
        ) u_cc (
            .clk      (clk),
            .rst_     (rst_),
            .inc      (icredit[v]),
            .dec      (dec_s[v]),
            .count    (credit_s[v]),
            .overflow (ovf_s[v])
        );
    end

    // Idle-state arbitration: a HEAD with credit on its VC is a candidate; rr breaks ties.
    always_comb begin
        cand0_s = ivalid_0 && (itype_0 == FLIT_HEAD) && (credit_s[ivch_0] != '0);
        cand1_s = ivalid_1 && (itype_1 == FLIT_HEAD) && (credit_s[ivch_1] != '0);
        if (cand0_s && cand1_s) begin
            win_any_s  = 1'b1;
            win_port_s = rr_r;
        end else if (cand0_s) begin
            win_any_s  = 1'b1;
            win_port_s = 1'b0;
        end else if (cand1_s) begin
            win_any_s  = 1'b1;
            win_port_s = 1'b1;
        end else begin
            win_any_s  = 1'b0;
            win_port_s = rr_r;
        end
    end

    // Busy-state grant: the owning port moves a flit whenever it is valid and the locked VC has credit.
    always_comb begin
        act_port_s  = (state_r == ST_BUSY1);
        act_valid_s = act_port_s ? ivalid_1 : ivalid_0;
        act_type_s  = act_port_s ? itype_1 : itype_0;
        lock_ok_s   = (credit_s[lock_vc_r] != '0);
        gnt0_s      = 1'b0;
        gnt1_s      = 1'b0;
        case (state_r)
            ST_BUSY0: gnt0_s = ivalid_0 & lock_ok_s;
            ST_BUSY1: gnt1_s = ivalid_1 & lock_ok_s;
            default: begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        endcase
        gnt_s = gnt0_s | gnt1_s;
    end

    // The packet's own HEAD is the first flit granted in BUSY; any later HEAD, or a valid NONE, is a protocol error.
    always_comb begin
        if (state_r != ST_IDLE) begin
            if (act_valid_s && (act_type_s == FLIT_NONE)) begin
                proto_err_s = 1'b1;
            end else if (gnt_s && (act_type_s == FLIT_HEAD) && !first_r) begin
                proto_err_s = 1'b1;
            end else begin
                proto_err_s = 1'b0;
            end
        end else begin
            proto_err_s = 1'b0;
        end
    end

    // Arbiter FSM with registered mux select, VC lock and round-robin pointer.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r   <= ST_IDLE;
            sel_r     <= 2'b00;
            rr_r      <= 1'b0;
            lock_vc_r <= '0;
            first_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_any_s) begin
                        state_r   <= win_port_s ? ST_BUSY1 : ST_BUSY0;
                        sel_r     <= port_onehot(win_port_s);
                        lock_vc_r <= win_port_s ? ivch_1 : ivch_0;
                        first_r   <= 1'b1;
                    end
                end
                ST_BUSY0, ST_BUSY1: begin
                    if (gnt_s) begin
                        first_r <= 1'b0;
                        if (act_type_s == FLIT_TAIL) begin
                            state_r <= ST_IDLE;
                            sel_r   <= 2'b00;
                            rr_r    <= ~act_port_s;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    sel_r   <= 2'b00;
                end
            endcase
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            oerr_r <= 1'b0;
        end else if (proto_err_s || (|ovf_s)) begin
            oerr_r <= 1'b1;
        end
    end

    assign sel      = sel_r;
    assign ogrant_0 = gnt0_s;
    assign ogrant_1 = gnt1_s;
    assign oerr     = oerr_r;

endmodule
